// File: rtl/odd_even_pkg.sv
// Shared types and helpers for the odd/even sequence controller.
// seed_value() doubles as the reference seed model for benches.
package odd_even_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int SEQ_STEP = 2;
  localparam int SEED_W   = 32;

  // Even runs start at 0, odd runs at 1; callers truncate to their width.
  function automatic logic [SEED_W-1:0] seed_value(input logic is_even);
    return {{(SEED_W-1){1'b0}}, ~is_even};
  endfunction

endpackage

// File: rtl/odd_even_step.sv
// Registered value / remaining-count datapath: loads a seed and count,
// then steps the value by SEQ_STEP and flags the final beat.
module odd_even_step
  import odd_even_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic             clear,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] value,
  output logic             last
);

  logic [CNT_W-1:0] remaining;

  // NOTE: every register here uses <= so all three update from the same
  // pre-edge values; blocking would let 'last' see the new 'remaining'.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value     <= '0;
      remaining <= '0;
      last      <= 1'b0;
    end else if (clear) begin
      last <= 1'b0;
    end else if (load) begin
      value     <= seed;
      remaining <= count;
      last      <= (count == CNT_W'(1));
    end else if (advance) begin
      // Modulo-2^WIDTH add keeps parity across wrap-around.
      value     <= value + WIDTH'(SEQ_STEP);
      remaining <= remaining - CNT_W'(1);
      last      <= (remaining == CNT_W'(2));
    end
  end

endmodule

// File: rtl/odd_even_seq_ctrl.sv
// Sequencing controller: streams a programmed number of even or odd values
// over a valid/ready interface, then pulses done.
module odd_even_seq_ctrl
  import odd_even_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_even,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  state_e state, state_next;
  logic   load, advance, clear;
  logic   fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Outputs decode the state register only, so out_ready never reaches them
  // combinationally.
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign out_valid = busy;
  assign fire      = out_valid && out_ready;

  // NOTE: defaults first so every path assigns every signal; otherwise
  // synthesis infers latches for the uncovered cases.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    clear      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_next = ST_RUN;
            load       = 1'b1;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        // Abort wins over a simultaneous final transfer: no done is raised.
        if (abort) begin
          state_next = ST_IDLE;
          clear      = 1'b1;
        end else if (fire && out_last) begin
          state_next = ST_DONE;
          clear      = 1'b1;
        end else if (fire) begin
          advance = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  odd_even_step #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .advance(advance),
    .clear  (clear),
    .seed   (WIDTH'(seed_value(is_even))),
    .count  (count),
    .value  (out_data),
    .last   (out_last)
  );

endmodule

// File: tb/tb_odd_even_seq_ctrl.sv
// Directed bench for odd_even_seq_ctrl: an 8-bit instance for most runs and
// a 4-bit instance for the wrap-around case.
module tb_odd_even_seq_ctrl;
  import odd_even_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start = 1'b0, is_even = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [7:0] count = '0;
  logic       out_valid, out_last, busy, done;
  logic [7:0] out_data;

  logic       start4 = 1'b0, is_even4 = 1'b0, abort4 = 1'b0, out_ready4 = 1'b0;
  logic [7:0] count4 = '0;
  logic       out_valid4, out_last4, busy4, done4;
  logic [3:0] out_data4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  odd_even_seq_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_even(is_even), .count(count),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  odd_even_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .is_even(is_even4), .count(count4),
    .abort(abort4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .out_last(out_last4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_last"},  32'(out_last),  32'd0);
  endtask

  initial begin
    int k;

    // Reset state
    #2;
    check_idle("rst");
    check("rst_data", 32'(out_data), 32'd0);
    check("rst4_valid", 32'(out_valid4), 32'd0);
    #10 rst_n = 1'b1;
    step();

    // 1: even, 20 beats, no backpressure
    out_ready = 1'b1; is_even = 1'b1; count = 8'd20; start = 1'b1;
    step();
    start = 1'b0; is_even = 1'b0; count = 8'd3;
    for (int i = 0; i < 20; i++) begin
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_busy",  32'(busy),      32'd1);
      check("t1_data",  32'(out_data),  32'(2 * i));
      check("t1_last",  32'(out_last),  32'(i == 19));
      step();
    end
    check("t1_done",  32'(done),      32'd1);
    check("t1_valid_off", 32'(out_valid), 32'd0);
    check("t1_last_off",  32'(out_last),  32'd0);
    step();
    check("t1_done_pulse", 32'(done), 32'd0);

    // 2: odd, 20 beats, ready toggling every cycle
    is_even = 1'b0; count = 8'd20; start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 60 && k < 20; cyc++) begin
      out_ready = (cyc % 2 == 0);
      check("t2_valid", 32'(out_valid), 32'd1);
      check("t2_data",  32'(out_data),  32'(2 * k + 1));
      check("t2_last",  32'(out_last),  32'(k == 19));
      if (out_ready) k++;
      step();
    end
    check("t2_beats", 32'(k), 32'd20);
    check("t2_done",  32'(done), 32'd1);
    out_ready = 1'b1;
    step();

    // 3: zero count goes straight to DONE
    count = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("t3_done",  32'(done),      32'd1);
    check("t3_busy",  32'(busy),      32'd0);
    check("t3_valid", 32'(out_valid), 32'd0);
    step();
    check_idle("t3_after");

    // 4: 4-bit wrap-around, odd, 10 beats
    out_ready4 = 1'b1; is_even4 = 1'b0; count4 = 8'd10; start4 = 1'b1;
    step();
    start4 = 1'b0;
    begin
      logic [3:0] exp4 [10] = '{1, 3, 5, 7, 9, 11, 13, 15, 1, 3};
      for (int i = 0; i < 10; i++) begin
        check("t4_valid", 32'(out_valid4), 32'd1);
        check("t4_data",  32'(out_data4),  32'(exp4[i]));
        check("t4_last",  32'(out_last4),  32'(i == 9));
        step();
      end
    end
    check("t4_done", 32'(done4), 32'd1);
    step();

    // 5: abort after the value-8 beat, then restart
    is_even = 1'b1; count = 8'd20; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t5_data", 32'(out_data), 32'(2 * i));
      step();
    end
    check("t5_pre_abort", 32'(out_data), 32'd10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("t5_abort");
    step();
    check("t5_no_done", 32'(done), 32'd0);
    count = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    check("t5_restart_valid", 32'(out_valid), 32'd1);
    check("t5_restart_data",  32'(out_data),  32'd0);
    for (int i = 0; i < 3; i++) step();
    check("t5_restart_done", 32'(done), 32'd1);
    step();

    // 6: asynchronous reset mid-run, then ignored starts in RUN and DONE
    is_even = 1'b0; count = 8'd20; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("t6_pre_rst", 32'(out_data), 32'd15);
    #2 rst_n = 1'b0;
    #1;
    check_idle("t6_rst");
    check("t6_rst_data", 32'(out_data), 32'd0);
    #2 rst_n = 1'b1;
    step();
    check_idle("t6_after_rst");

    count = 8'd2; start = 1'b1;
    step();
    check("t6_run_data", 32'(out_data), 32'd1);
    count = 8'd5; is_even = 1'b1;          // start held high through RUN
    step();
    check("t6_run_data2", 32'(out_data), 32'd3);
    check("t6_run_last",  32'(out_last), 32'd1);
    step();
    check("t6_done", 32'(done), 32'd1);   // start still high in DONE
    step();
    start = 1'b0;
    check_idle("t6_ignored");
    step();
    check_idle("t6_ignored2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
